// File: rtl/cook_pkg.sv
// Shared cooking-slot types and default timing for timer, display and scoring.
package cook_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COOKING = 2'd1,
        READY   = 2'd2,
        BURNT   = 2'd3
    } cook_state_t;

    localparam int COOK_TIME_DEF = 10;
    localparam int BURN_TIME_DEF = 5;
    localparam int CNT_W_DEF     = 8;

endpackage

// File: rtl/cook_timer_phase_counter.sv
// Elapsed-tick counter for one cooking phase with a registered terminal flag.
module phase_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] count,
    output logic             hit
);

    logic [CNT_W-1:0] count_d, count_q;
    logic             hit_d, hit_q;

    // term refers to the phase the counter is entering, so hit is ready a cycle early
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + 1'b1;
        end
        hit_d = (count_d == term);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            hit_q   <= hit_d;
        end
    end

    assign count = count_q;
    assign hit   = hit_q;

endmodule

// File: rtl/cook_timer.sv
// Per-slot cooking FSM: IDLE -> COOKING -> READY -> BURNT with event pulses.
// Optional pause input enabled by defining COOK_TIMER_PAUSE_EN.
module cook_timer
    import cook_pkg::*;
#(
    parameter int COOK_TIME = COOK_TIME_DEF,
    parameter int BURN_TIME = BURN_TIME_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             start,
    input  logic             remove,
`ifdef COOK_TIMER_PAUSE_EN
    input  logic             pause,
`endif
    output logic [1:0]       state,
    output logic [CNT_W-1:0] elapsed,
    output logic             ready_pulse,
    output logic             burnt_pulse,
    output logic             served_pulse,
    output logic             waste_pulse
);

    if (COOK_TIME < 1 || COOK_TIME > (2**CNT_W) - 1) begin : g_bad_cook
        $error("cook_timer: COOK_TIME out of range for CNT_W");
    end
    if (BURN_TIME < 1 || BURN_TIME > (2**CNT_W) - 1) begin : g_bad_burn
        $error("cook_timer: BURN_TIME out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] COOK_TERM = CNT_W'(COOK_TIME - 1);
    localparam logic [CNT_W-1:0] BURN_TERM = CNT_W'(BURN_TIME - 1);

    cook_state_t      state_d, state_q;
    logic             ready_d, ready_q;
    logic             burnt_d, burnt_q;
    logic             served_d, served_q;
    logic             waste_d, waste_q;
    logic             clr, inc, hit, tick_ok;
    logic [CNT_W-1:0] term;

`ifdef COOK_TIMER_PAUSE_EN
    assign tick_ok = tick & ~pause;
`else
    assign tick_ok = tick;
`endif

    always_comb begin
        state_d  = state_q;
        clr      = 1'b0;
        inc      = 1'b0;
        ready_d  = 1'b0;
        burnt_d  = 1'b0;
        served_d = 1'b0;
        waste_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                clr = 1'b1;
                if (start) state_d = COOKING;
            end
            COOKING: begin
                if (remove) begin
                    state_d = IDLE;
                    clr     = 1'b1;
                    waste_d = 1'b1;
                end else if (tick_ok) begin
                    if (hit) begin
                        state_d = READY;
                        clr     = 1'b1;
                        ready_d = 1'b1;
                    end else begin
                        inc = 1'b1;
                    end
                end
            end
            READY: begin
                if (remove) begin
                    state_d  = IDLE;
                    clr      = 1'b1;
                    served_d = 1'b1;
                end else if (tick_ok) begin
                    if (hit) begin
                        state_d = BURNT;
                        clr     = 1'b1;
                        burnt_d = 1'b1;
                    end else begin
                        inc = 1'b1;
                    end
                end
            end
            BURNT: begin
                clr = 1'b1;
                if (remove) begin
                    state_d = IDLE;
                    waste_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign term = (state_d == READY) ? BURN_TERM : COOK_TERM;

    phase_counter #(.CNT_W(CNT_W)) u_phase (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (clr),
        .inc     (inc),
        .term    (term),
        .count   (elapsed),
        .hit     (hit)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            burnt_q  <= 1'b0;
            served_q <= 1'b0;
            waste_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            burnt_q  <= burnt_d;
            served_q <= served_d;
            waste_q  <= waste_d;
        end
    end

    assign state        = state_q;
    assign ready_pulse  = ready_q;
    assign burnt_pulse  = burnt_q;
    assign served_pulse = served_q;
    assign waste_pulse  = waste_q;

endmodule
